output_reader: RTL and testbench

- Reads computed output rows back out of the activation/output BRAM (matrix A) after a TPU run and streams them to a consumer over a valid/ready interface.
- It is the read-side counterpart of the top-level output write stage. It walks the same address sequence that stage uses to write rows, in both normal and conv mode.
- It presents addresses to a 1-cycle-latency BRAM read port. A 2-entry output FIFO absorbs read latency under backpressure.

---
 rtl/output_reader.sv | 154 +++++++++++++++
 tb/tb_output_reader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_reader.sv
// Streams computed rows back out of the output BRAM, walking the same address
// sequence the output write stage uses, through a 2-entry FIFO to a valid/ready consumer.
module output_reader #(
  parameter int AWIDTH            = 10,
  parameter int DWIDTH            = 8,
  parameter int MAT_MUL_SIZE      = 4,
  parameter int ADDR_STRIDE_WIDTH = 8,
  parameter int MASK_WIDTH        = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [AWIDTH-1:0]              base_addr,
  input  logic [ADDR_STRIDE_WIDTH-1:0]   address_stride,
  input  logic                           conv_mode,
  input  logic [15:0]                    out_img_height,
  input  logic [15:0]                    out_img_width,
  input  logic [7:0]                     num_rows,
  input  logic [MASK_WIDTH-1:0]          validity_mask,
  output logic [AWIDTH-1:0]              bram_addr,
  output logic                           bram_en,
  input  logic [MAT_MUL_SIZE*DWIDTH-1:0] bram_rdata,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0] out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           busy,
  output logic                           done
);

  localparam int RWIDTH = MAT_MUL_SIZE * DWIDTH;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]            state;
  logic [AWIDTH-1:0]     row_addr;
  logic [AWIDTH-1:0]     addr_step;
  logic [AWIDTH-1:0]     conv_step;
  logic                  conv_lat;
  logic                  zero_run;
  logic [7:0]            rows_total;
  logic [7:0]            rows_issued;
  logic [MASK_WIDTH-1:0] mask_lat;
  logic                  in_flight;

  logic [RWIDTH-1:0]     fifo_mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            fifo_count;
  logic [1:0]            count_next;
  logic [2:0]            occupancy;
  logic                  fifo_wr;
  logic                  fifo_pop;
  logic                  issue;
  logic [RWIDTH-1:0]     masked_rdata;

  // Conv step is the full 32-bit product, only its low AWIDTH bits matter for addressing.
  assign conv_step = AWIDTH'(32'(out_img_height) * 32'(out_img_width));

  assign out_valid  = (fifo_count != 2'd0);
  assign out_data   = fifo_mem[rd_ptr];
  assign fifo_pop   = out_valid & out_ready;
  assign fifo_wr    = in_flight;
  assign count_next = fifo_count + 2'(fifo_wr) - 2'(fifo_pop);

  // A row popped this cycle frees its slot in time for the read issued now,
  // which keeps full throughput without ever exceeding two buffered rows.
  assign occupancy = 3'(fifo_count) + 3'(in_flight) - 3'(fifo_pop);
  assign issue     = (state == READ) && (occupancy < 3'd2);

  assign bram_en   = issue;
  assign bram_addr = row_addr;
  assign done      = (state == DONE);
  assign busy      = (state == READ) || (state == DRAIN) || ((state == DONE) && zero_run);

  always_comb begin
    masked_rdata = '0;
    for (int i = 0; i < MAT_MUL_SIZE; i++) begin
      if (mask_lat[i]) masked_rdata[i*DWIDTH +: DWIDTH] = bram_rdata[i*DWIDTH +: DWIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      row_addr    <= '0;
      addr_step   <= '0;
      conv_lat    <= 1'b0;
      zero_run    <= 1'b0;
      rows_total  <= '0;
      rows_issued <= '0;
      mask_lat    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            row_addr    <= base_addr;
            addr_step   <= conv_mode ? conv_step : AWIDTH'(address_stride);
            conv_lat    <= conv_mode;
            rows_total  <= num_rows;
            rows_issued <= '0;
            mask_lat    <= validity_mask;
            zero_run    <= (num_rows == 8'd0);
            state       <= (num_rows == 8'd0) ? DONE : READ;
          end
        end
        READ: begin
          if (issue) begin
            row_addr    <= conv_lat ? row_addr + addr_step : row_addr - addr_step;
            rows_issued <= rows_issued + 8'd1;
            if (rows_issued + 8'd1 == rows_total) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!in_flight && count_next == 2'd0) state <= DONE;
        end
        DONE: begin
          zero_run <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) in_flight <= 1'b0;
    else       in_flight <= issue;
  end

  // Read data lands one cycle after bram_en and is masked on its way into the FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_count  <= 2'd0;
    end else begin
      if (fifo_wr) begin
        fifo_mem[wr_ptr] <= masked_rdata;
        wr_ptr           <= ~wr_ptr;
      end
      if (fifo_pop) rd_ptr <= ~rd_ptr;
      fifo_count <= count_next;
    end
  end

  fifo_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(fifo_wr && !fifo_pop && fifo_count == 2'd2));

endmodule

// File: tb/tb_output_reader.sv
// Scoreboard bench for output_reader: a BRAM model, expected rows queued at start,
// and a negedge monitor that checks addresses, data, holds and done pulses.
`timescale 1ns/1ps
module tb_output_reader;
  localparam int AWIDTH = 10;
  localparam int RW     = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [AWIDTH-1:0] base_addr;
  logic [7:0]        address_stride;
  logic              conv_mode;
  logic [15:0]       out_img_height;
  logic [15:0]       out_img_width;
  logic [7:0]        num_rows;
  logic [3:0]        validity_mask;
  logic [AWIDTH-1:0] bram_addr;
  logic              bram_en;
  logic [RW-1:0]     bram_rdata = '0;
  logic [RW-1:0]     out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;

  logic [RW-1:0]     mem [0:1023];
  logic [AWIDTH-1:0] exp_addr_q [$];
  logic [RW-1:0]     exp_data_q [$];

  int check_count = 0;
  int fail_count  = 0;
  int issued      = 0;
  int accepted    = 0;
  int done_count  = 0;
  int ready_mode  = 0;
  int ready_phase = 0;
  logic          prev_stall = 1'b0;
  logic [RW-1:0] held_data  = '0;

  always #5 clk = ~clk;

  output_reader dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .address_stride(address_stride), .conv_mode(conv_mode),
    .out_img_height(out_img_height), .out_img_width(out_img_width),
    .num_rows(num_rows), .validity_mask(validity_mask),
    .bram_addr(bram_addr), .bram_en(bram_en), .bram_rdata(bram_rdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always @(posedge clk) if (bram_en) bram_rdata <= mem[bram_addr];

  function automatic logic [RW-1:0] pattern(input logic [AWIDTH-1:0] a);
    return 32'h11223344 + {22'd0, a};
  endfunction

  function automatic logic [RW-1:0] lane_mask(input logic [3:0] m);
    logic [RW-1:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) if (m[i]) r[i*8 +: 8] = 8'hFF;
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Queues the expected address/data sequence, pulses start, then scrambles the config.
  task automatic applyStimulus(input int base, input int stride, input logic conv,
                               input int h, input int w, input int rows, input logic [3:0] mask);
    for (int k = 0; k < rows; k++) begin
      int a;
      if (conv) a = base + k * h * w;
      else      a = base - k * stride;
      a = a & 1023;
      exp_addr_q.push_back(a[9:0]);
      exp_data_q.push_back(pattern(a[9:0]) & lane_mask(mask));
    end
    @(posedge clk); #1;
    base_addr      = AWIDTH'(base);
    address_stride = 8'(stride);
    conv_mode      = conv;
    out_img_height = 16'(h);
    out_img_width  = 16'(w);
    num_rows       = 8'(rows);
    validity_mask  = mask;
    start          = 1'b1;
    @(posedge clk); #1;
    start          = 1'b0;
    base_addr      = ~base_addr;
    address_stride = address_stride + 8'd3;
    conv_mode      = ~conv_mode;
    num_rows       = num_rows + 8'd2;
    validity_mask  = ~validity_mask;
  endtask

  task automatic waitDone(input int budget, input string tag);
    bit seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checkOutput({tag, "_done"}, 32'(seen), 32'd1);
    checkOutput({tag, "_rows_left"}, 32'(exp_data_q.size()), 32'd0);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_bram_addr"}, 32'(bram_addr), 32'd0);
    checkOutput({tag, "_bram_en"},   32'(bram_en),   32'd0);
    checkOutput({tag, "_out_data"},  out_data,       32'd0);
    checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_busy"},      32'(busy),      32'd0);
    checkOutput({tag, "_done"},      32'(done),      32'd0);
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (ready_mode != 0) begin
        out_ready   = (ready_phase == 0);
        ready_phase = (ready_phase + 1) % 3;
      end else begin
        out_ready   = 1'b1;
        ready_phase = 0;
      end
    end
  end

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      issued     = 0;
      accepted   = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checkOutput("hold_valid", 32'(out_valid), 32'd1);
        checkOutput("hold_data", out_data, held_data);
      end
      if (bram_en) begin
        int occ;
        occ = issued - accepted + 1 - ((out_valid && out_ready) ? 1 : 0);
        checkOutput("occupancy", 32'(occ <= 2), 32'd1);
        if (exp_addr_q.size() == 0) checkOutput("unexpected_read", 32'(bram_en), 32'd0);
        else checkOutput("read_addr", 32'(bram_addr), 32'(exp_addr_q.pop_front()));
        issued++;
      end
      if (out_valid && out_ready) begin
        if (exp_data_q.size() == 0) checkOutput("extra_row", 32'(out_valid), 32'd0);
        else checkOutput("row_data", out_data, exp_data_q.pop_front());
        accepted++;
      end
      if (done) done_count++;
      prev_stall = out_valid && !out_ready;
      held_data  = out_data;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", check_count);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int first_en, first_valid, done_at, n_valid, base_done, base_acc;
    bit reached;
    for (int i = 0; i < 1024; i++) mem[i] = pattern(10'(i));
    reset = 1'b1; start = 1'b0; base_addr = '0; address_stride = '0; conv_mode = 1'b0;
    out_img_height = '0; out_img_width = '0; num_rows = '0; validity_mask = '0;
    repeat (2) @(posedge clk);
    #1;
    checkIdleOutputs("reset");
    reset = 1'b0;

    $display("[TB] normal mode, latency");
    base_done = done_count;
    applyStimulus(100, 4, 1'b0, 0, 0, 4, 4'hF);
    first_en = -1; first_valid = -1; done_at = -1; n_valid = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (bram_en && first_en < 0) first_en = n;
      if (out_valid) begin
        if (first_valid < 0) first_valid = n;
        n_valid++;
      end
      if (done && done_at < 0) done_at = n;
    end
    checkOutput("t1_first_en", first_en, 1);
    checkOutput("t1_first_valid", first_valid, 3);
    checkOutput("t1_valid_cycles", n_valid, 4);
    checkOutput("t1_done_at", done_at, 7);
    checkOutput("t1_rows_left", 32'(exp_data_q.size()), 32'd0);
    checkOutput("t1_done_pulses", done_count - base_done, 1);

    $display("[TB] conv mode");
    base_done = done_count;
    applyStimulus(10, 0, 1'b1, 2, 3, 3, 4'hF);
    waitDone(30, "t2");
    repeat (3) @(negedge clk);
    checkOutput("t2_done_pulses", done_count - base_done, 1);

    $display("[TB] backpressure");
    ready_mode = 1;
    applyStimulus(300, 7, 1'b0, 0, 0, 5, 4'hF);
    waitDone(80, "t3");
    ready_mode = 0;

    $display("[TB] mask and wrap");
    applyStimulus(2, 4, 1'b0, 0, 0, 2, 4'b0101);
    waitDone(30, "t4");

    $display("[TB] zero rows");
    applyStimulus(5, 1, 1'b0, 0, 0, 0, 4'hF);
    @(negedge clk);
    checkOutput("t5_zero_done", 32'(done), 32'd1);
    checkOutput("t5_zero_en", 32'(bram_en), 32'd0);
    repeat (4) @(negedge clk);

    $display("[TB] start while busy");
    base_done = done_count;
    applyStimulus(50, 2, 1'b0, 0, 0, 3, 4'hF);
    num_rows = 8'd7;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    waitDone(30, "t5b");
    repeat (10) @(negedge clk);
    checkOutput("t5b_done_pulses", done_count - base_done, 1);

    $display("[TB] reset mid-run");
    base_acc = accepted;
    applyStimulus(400, 1, 1'b0, 0, 0, 6, 4'hF);
    reached = 1'b0;
    for (int n = 0; n < 30 && !reached; n++) begin
      @(negedge clk);
      if (accepted - base_acc >= 2) reached = 1'b1;
    end
    checkOutput("t6_two_accepted", 32'(reached), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    checkIdleOutputs("t6_reset");
    exp_addr_q.delete();
    exp_data_q.delete();
    reset = 1'b0;
    base_done = done_count;
    repeat (6) @(negedge clk);
    checkOutput("t6_no_done", done_count - base_done, 0);
    applyStimulus(20, 1, 1'b0, 0, 0, 1, 4'hF);
    waitDone(20, "t6_fresh");

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
